// File: rtl/layer_bridge_fifo.sv
// Inter-layer stream buffer: valid/ready on both sides, first-word-fall-through output register
// in front of a (DEPTH-1)-word RAM, almost-full warning, sticky overflow and frame-end tagging.
`timescale 1ns/1ps
module layer_bridge_fifo #(
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 1024,
  parameter int AFULL_THRESH = DEPTH - 16,
  parameter int FRAME_LEN    = 169
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);
  // Handshake: a word moves on a side only in a cycle where that side's valid and ready are both
  // high at the rising edge; in_ready is registered, so no ready path depends on out_ready.

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH - 1);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int RW = 1 << PW;

  logic [DATA_WIDTH-1:0] ram_q [RW];

  logic [LW-1:0]         level_q, level_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         fcnt_q, fcnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  afull_q, afull_d;
  logic                  ovf_q, ovf_d;
  logic                  ram_we;
  logic                  push, pop, drop, bypass, ram_empty, flush;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 2)) ? '0 : p + PW'(1);
  endfunction

  assign flush     = rst | clear;
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid_q & out_ready;
  assign drop      = in_valid & ~in_ready_q;
  // The RAM holds everything except the word sitting in the output register.
  assign ram_empty = (level_q == {{(LW-1){1'b0}}, out_valid_q});
  assign bypass    = push & (~out_valid_q | (pop & ram_empty));

  always_comb begin
    level_d     = level_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fcnt_d      = fcnt_q;
    in_ready_d  = in_ready_q;
    afull_d     = afull_q;
    ovf_d       = ovf_q;
    ram_we      = 1'b0;
    if (flush) begin
      level_d     = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      fcnt_d      = '0;
      in_ready_d  = 1'b1;
      afull_d     = 1'b0;
      ovf_d       = 1'b0;
    end else begin
      if (drop) ovf_d = 1'b1;
      if (push && !bypass) begin
        ram_we   = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (bypass) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else if (pop) begin
        if (ram_empty) begin
          out_valid_d = 1'b0;
        end else begin
          out_data_d = ram_q[rd_ptr_q];
          rd_ptr_d   = ptr_inc(rd_ptr_q);
        end
      end
      if (pop) fcnt_d = (fcnt_q == CW'(FRAME_LEN - 1)) ? '0 : fcnt_q + CW'(1);
      unique case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      in_ready_d = (level_d != LW'(DEPTH));
      afull_d    = (level_d >= LW'(AFULL_THRESH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
      in_ready_q  <= 1'b1;
      afull_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
      in_ready_q  <= in_ready_d;
      afull_q     <= afull_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[wr_ptr_q] <= in_data;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_valid_q & (fcnt_q == CW'(FRAME_LEN - 1));
  assign almost_full = afull_q;
  assign level       = level_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_layer_bridge_fifo.sv
// Directed bench for layer_bridge_fifo: a queue model tracks contents, level and frame position;
// every cycle compares status and head word against it, plus hand-computed checkpoints.
`timescale 1ns/1ps
module tb_layer_bridge_fifo;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int FL    = 169;

  logic          clk = 1'b0;
  logic          rst, clear, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, out_last, almost_full, overflow;
  logic [DW-1:0] out_data;
  logic [4:0]    level;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  int m_level = 0;
  bit m_ovf   = 1'b0;
  int m_fcnt  = 0;
  int pops_total = 0;
  int n_last = 0;
  int first_last = -1;
  int pushed;

  always #5 clk = ~clk;

  layer_bridge_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF), .FRAME_LEN(FL)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_last(out_last), .almost_full(almost_full), .level(level), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock: score the handshake about to happen, advance the model, step, compare status.
  task automatic cycle();
    bit acc, pp, drp;
    logic [DW-1:0] head;
    if (rst || clear) begin
      @(posedge clk); #1;
      exp_q.delete();
      m_level = 0;
      m_ovf   = 1'b0;
      m_fcnt  = 0;
    end else begin
      acc = in_valid && (m_level < DEPTH);
      pp  = out_ready && (m_level > 0);
      drp = in_valid && (m_level == DEPTH);
      if (pp) begin
        head = exp_q.pop_front();
        chk("pop_data", out_data, head);
        chk("pop_last", out_last, (m_fcnt == FL - 1));
        if (out_last) begin
          n_last++;
          if (first_last < 0) first_last = pops_total;
        end
        pops_total++;
        m_fcnt = (m_fcnt == FL - 1) ? 0 : m_fcnt + 1;
      end
      if (acc) exp_q.push_back(in_data);
      m_level = m_level + int'(acc) - int'(pp);
      if (drp) m_ovf = 1'b1;
      @(posedge clk); #1;
    end
    chk("level", level, m_level);
    chk("in_ready", in_ready, (m_level != DEPTH));
    chk("out_valid", out_valid, (m_level != 0));
    chk("almost_full", almost_full, (m_level >= AF));
    chk("overflow", overflow, m_ovf);
    if (m_level > 0) chk("head", out_data, exp_q[0]);
    else             chk("last_idle", out_last, 1'b0);
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic drain();
    drive(1'b0, '0, 1'b1);
    for (int n = 0; n < DEPTH + 4 && m_level > 0; n++) cycle();
    chk("drain_level", level, 0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    drive(1'b0, '0, 1'b0);
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    drive(1'b1, 16'h0077, 1'b0);
    cycle();
    chk("rst_push_ignored", level, 0);
    chk("rst_out_data2", out_data, 0);
    rst = 1'b0;

    // Basic FWFT: word visible right after its push edge
    drive(1'b1, 16'd5, 1'b0);
    cycle();
    chk("fwft_valid", out_valid, 1);
    chk("fwft_data", out_data, 5);
    chk("fwft_level", level, 1);
    drive(1'b0, '0, 1'b1);
    cycle();
    chk("fwft_pop_level", level, 0);
    drive(1'b0, '0, 1'b0);
    pulse_clear();

    // Streaming 0..999 with the consumer always ready
    n_last = 0; first_last = -1; pops_total = 0;
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, DW'(i), 1'b1);
      cycle();
      chk("stream_level_max", (level <= 5'd2), 1);
    end
    drain();
    chk("stream_last_count", n_last, 5);
    chk("stream_first_last", first_last, 168);
    chk("stream_pops", pops_total, 1000);
    pulse_clear();

    // Fill past full with the consumer stalled
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, DW'(k), 1'b0);
      cycle();
      chk("fill_level", level, (k < 16) ? k : 16);
      chk("fill_afull", almost_full, (k >= 12));
      chk("fill_in_ready", in_ready, (k < 16));
      chk("fill_overflow", overflow, (k >= 17));
    end

    // Push and pop together while full: pop wins, push drops
    drive(1'b1, 16'd99, 1'b1);
    cycle();
    chk("simul_level", level, 15);
    chk("simul_in_ready", in_ready, 1);
    chk("simul_overflow", overflow, 1);
    chk("simul_head", out_data, 2);
    drain();
    chk("fill_overflow_sticky", overflow, 1);

    // Bring frame position to 100 with the buffer empty, then hold 7 words
    for (int n = 0; n < 300 && m_fcnt < 99; n++) begin
      drive(1'b1, DW'(16'h4000 + n), 1'b1);
      cycle();
    end
    drive(1'b0, '0, 1'b1);
    cycle();
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, DW'(200 + k), 1'b0);
      cycle();
    end
    chk("pre_clear_level", level, 7);
    chk("pre_clear_overflow", overflow, 1);

    // Clear coinciding with a push and a pop
    drive(1'b1, 16'h0bad, 1'b1);
    pulse_clear();
    chk("clr_level", level, 0);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_overflow", overflow, 0);
    chk("clr_out_last", out_last, 0);
    n_last = 0; first_last = -1; pops_total = 0;
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, DW'(1000 + i), 1'b1);
      cycle();
    end
    drain();
    chk("clr_first_last", first_last, 168);
    chk("clr_last_count", n_last, 1);

    // Wrap-around with a randomly stalling consumer
    pulse_clear();
    pushed = 0;
    for (int n = 0; n < 5000 && pushed < 500; n++) begin
      drive((m_level < DEPTH), DW'($urandom_range(0, 16'hffff)), 1'($urandom_range(0, 1)));
      if (in_valid) pushed++;
      cycle();
    end
    drain();
    chk("wrap_overflow", overflow, 0);
    chk("wrap_pushed", pushed, 500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
